bist_response_analyzer: RTL and testbench

Output-side BIST block for the 4-bit datapath. While a test runs, it drives the select of the input mux to route test-pattern-generator data into the circuit under test (CUT). Each cycle it compresses the CUT's 4-bit response into a multiple-input signature register (MISR). After a fixed pattern count it compares the signature with a golden value and reports pass/fail.

---
 rtl/bist_pkg.sv | 28 ++
 rtl/misr4.sv | 43 ++++
 rtl/bist_response_analyzer.sv | 134 +++++++++++++
 tb/tb_bist_response_analyzer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyzer.
//   - bist_state_e : analyzer FSM states
//   - MisrWidth    : signature register width
//   - MisrTaps     : feedback mask for x^4+x+1 (feeds bits 0 and 1)
//   - misr_next()  : one MISR compression step
package bist_pkg;

  localparam int unsigned MisrWidth = 4;

  // Bit 3 shifts out and is fed back into bits 0 and 1.
  localparam logic [MisrWidth-1:0] MisrTaps = 4'b0011;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StCompare = 2'd2,
    StDone    = 2'd3
  } bist_state_e;

  // Shift left, fold the outgoing MSB back through the tap mask, then absorb the data word.
  function automatic logic [MisrWidth-1:0] misr_next(input logic [MisrWidth-1:0] s,
                                                     input logic [MisrWidth-1:0] d);
    logic [MisrWidth-1:0] fb;
    fb = s[MisrWidth-1] ? MisrTaps : '0;
    return {s[MisrWidth-2:0], 1'b0} ^ fb ^ d;
  endfunction

endpackage

// File: rtl/misr4.sv
// 4-bit multiple-input signature register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, loads seed
//   load  : load seed (has priority over en)
//   en    : absorb d into the signature
//   seed  : initial signature value
//   d     : response word to compress
//   q     : current signature
module misr4
  import bist_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 en,
  input  logic [MisrWidth-1:0] seed,
  input  logic [MisrWidth-1:0] d,
  output logic [MisrWidth-1:0] q
);

  logic [MisrWidth-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = misr_next(sig_q, d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign q = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// Output-side BIST response analyzer for the 4-bit datapath.
// Steers the input mux to the test-pattern path while a run is active, compresses NPAT CUT
// response words into a MISR, then compares the signature against GOLDEN.
// Parameters:
//   NPAT   : response words captured per run (1..255)
//   SEED   : MISR value at reset and at every launch
//   GOLDEN : expected final signature
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : level launch request; must drop and rise again to relaunch
//   cut_out   : CUT response word, captured on every RUN edge
//   test_mode : registered mux select, 1 while in RUN
//   done      : registered, a result is present
//   pass      : registered, signature matched GOLDEN (valid with done)
//   sig       : current MISR contents, only when BIST_SIG_OUT_EN is defined
// Build option: define BIST_SIG_OUT_EN to expose the sig port.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned          NPAT   = 15,
  parameter logic [MisrWidth-1:0] SEED   = 4'h0,
  parameter logic [MisrWidth-1:0] GOLDEN = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MisrWidth-1:0] cut_out,
  output logic                 test_mode,
  output logic                 done,
  output logic                 pass
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MisrWidth-1:0] sig
`endif
);

  localparam int unsigned CntW = $clog2(NPAT + 1);
  // Counter value at which the final (NPAT-th) capture happens.
  localparam logic [CntW-1:0] CntLast = CntW'(NPAT - 1);

  bist_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 test_mode_q, test_mode_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 misr_load;
  logic                 misr_en;
  logic [MisrWidth-1:0] misr_q;

  misr4 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (misr_load),
    .en    (misr_en),
    .seed  (SEED),
    .d     (cut_out),
    .q     (misr_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    test_mode_d = test_mode_q;
    done_d      = done_q;
    pass_d      = pass_q;
    misr_load   = 1'b0;
    misr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          cnt_d       = '0;
          misr_load   = 1'b1;
          test_mode_d = 1'b1;
        end
      end
      StRun: begin
        // start is deliberately ignored here; the run length is fixed.
        misr_en = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d     = StCompare;
          test_mode_d = 1'b0;
        end
      end
      StCompare: begin
        pass_d  = (misr_q == GOLDEN);
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        // Holding start keeps the result; a relaunch needs start low first.
        if (!start) begin
          state_d = StIdle;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        test_mode_d = 1'b0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      test_mode_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      test_mode_q <= test_mode_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign test_mode = test_mode_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef BIST_SIG_OUT_EN
  assign sig = misr_q;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: hand-written sequences on small NPAT instances plus a
// table of response streams on an NPAT=3, SEED=5, GOLDEN=A instance checked through a
// scoreboard queue popped whenever that instance raises done.
module tb_bist_response_analyzer;
  import bist_pkg::*;

  logic clk;
  logic rst_n;

  logic       start_a, start_c, start_d;
  logic [3:0] cut_a, cut_c, cut_d;
  logic       tm_a, done_a, pass_a;
  logic       tm_b, done_b, pass_b;
  logic       tm_c, done_c, pass_c;
  logic       tm_d, done_d, pass_d;
  logic [3:0] sig_a, sig_b, sig_c, sig_d;

`ifndef BIST_SIG_OUT_EN
  assign sig_a = dut_a.misr_q;
  assign sig_b = dut_b.misr_q;
  assign sig_c = dut_c.misr_q;
  assign sig_d = dut_d.misr_q;
`endif

  bist_response_analyzer #(.NPAT(2), .SEED(4'h0), .GOLDEN(4'h3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cut_out(cut_a),
    .test_mode(tm_a), .done(done_a), .pass(pass_a)
`ifdef BIST_SIG_OUT_EN
    , .sig(sig_a)
`endif
  );

  bist_response_analyzer #(.NPAT(2), .SEED(4'h0), .GOLDEN(4'h2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cut_out(cut_a),
    .test_mode(tm_b), .done(done_b), .pass(pass_b)
`ifdef BIST_SIG_OUT_EN
    , .sig(sig_b)
`endif
  );

  bist_response_analyzer #(.NPAT(15), .SEED(4'h0), .GOLDEN(4'h0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .cut_out(cut_c),
    .test_mode(tm_c), .done(done_c), .pass(pass_c)
`ifdef BIST_SIG_OUT_EN
    , .sig(sig_c)
`endif
  );

  bist_response_analyzer #(.NPAT(3), .SEED(4'h5), .GOLDEN(4'hA)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .cut_out(cut_d),
    .test_mode(tm_d), .done(done_d), .pass(pass_d)
`ifdef BIST_SIG_OUT_EN
    , .sig(sig_d)
`endif
  );

  typedef struct {
    logic [3:0] w0;
    logic [3:0] w1;
    logic [3:0] w2;
    logic [3:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  typedef struct packed {
    logic [3:0] sig;
    logic       pass;
  } exp_t;

  vec_t vecs[4];
  exp_t sb_q[$];
  int   n_vec;
  int   n_miss;
  logic done_d_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; pops the scoreboard on a done rise of dut_d.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (done_d && !done_d_prev) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected_done: got done with empty queue, required no done");
      end else begin
        e = sb_q.pop_front();
        check("sb_sig", 32'(sig_d), 32'(e.sig));
        check("sb_pass", 32'(pass_d), 32'(e.pass));
      end
    end
    done_d_prev = done_d;
  endtask

  initial begin
    int bad;
    int lat;
    int tm_cnt;
    int nz;

    n_vec = 0;
    n_miss = 0;
    done_d_prev = 1'b0;
    // Hand-computed signatures for SEED=5 after three captures.
    vecs[0] = '{w0: 4'h0, w1: 4'h0, w2: 4'h0, exp_sig: 4'hE, exp_pass: 1'b0};
    vecs[1] = '{w0: 4'hF, w1: 4'hF, w2: 4'hF, exp_sig: 4'h5, exp_pass: 1'b0};
    vecs[2] = '{w0: 4'h1, w1: 4'h2, w2: 4'h4, exp_sig: 4'hA, exp_pass: 1'b1};
    vecs[3] = '{w0: 4'h8, w1: 4'h0, w2: 4'h3, exp_sig: 4'hB, exp_pass: 1'b0};

    rst_n = 1'b0;
    start_a = 1'b0; start_c = 1'b0; start_d = 1'b0;
    cut_a = 4'h0; cut_c = 4'h0; cut_d = 4'h0;
    tick();
    tick();
    check("rst_state", 32'(dut_a.state_q), 32'(StIdle));
    check("rst_test_mode", 32'(tm_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_sig_seed0", 32'(sig_a), 32'h0);
    check("rst_sig_seed5", 32'(sig_d), 32'h5);
    rst_n = 1'b1;
    tick();

    // Basic run, NPAT=2, cut_out=1.
    start_a = 1'b1; cut_a = 4'h1;
    tick();
    start_a = 1'b0;
    check("run_tm_k", 32'(tm_a), 1);
    check("run_sig_k", 32'(sig_a), 32'h0);
    tick();
    check("run_sig_k1", 32'(sig_a), 32'h1);
    check("run_tm_k1", 32'(tm_a), 1);
    tick();
    check("run_sig_k2", 32'(sig_a), 32'h3);
    check("run_tm_k2", 32'(tm_a), 0);
    check("run_done_k2", 32'(done_a), 0);
    tick();
    check("run_done_k3", 32'(done_a), 1);
    check("run_pass_k3", 32'(pass_a), 1);
    check("gold2_done", 32'(done_b), 1);
    check("gold2_pass", 32'(pass_b), 0);
    check("gold2_sig", 32'(sig_b), 32'h3);
    tick();
    check("done_clear", 32'(done_a), 0);
    check("pass_clear", 32'(pass_a), 0);

    // All-zero stream on NPAT=15.
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    tm_cnt = tm_c ? 1 : 0;
    nz = (sig_c != 4'h0) ? 1 : 0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_c) begin
        lat = i;
        break;
      end
      if (tm_c) tm_cnt++;
      if (sig_c != 4'h0) nz++;
    end
    check("n15_latency", 32'(lat), 16);
    check("n15_tm_cycles", 32'(tm_cnt), 15);
    check("n15_sig_nonzero", 32'(nz), 0);
    check("n15_pass", 32'(pass_c), 1);
    tick();

    // Reset after one capture.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check("midrst_sig_pre", 32'(sig_a), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_state", 32'(dut_a.state_q), 32'(StIdle));
    check("midrst_tm", 32'(tm_a), 0);
    check("midrst_done", 32'(done_a), 0);
    check("midrst_sig", 32'(sig_a), 32'h0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_a || tm_a) bad++;
    end
    check("midrst_no_done", 32'(bad), 0);

    // start held through DONE, then released and re-raised.
    start_a = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("hold_done", 32'(done_a), 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!done_a || tm_a || !pass_a) bad++;
    end
    check("hold_no_relaunch", 32'(bad), 0);
    start_a = 1'b0;
    tick();
    check("hold_release_done", 32'(done_a), 0);
    check("hold_release_state", 32'(dut_a.state_q), 32'(StIdle));
    start_a = 1'b1;
    tick();
    check("relaunch_tm", 32'(tm_a), 1);
    tick();
    tick();
    tick();
    check("relaunch_done", 32'(done_a), 1);
    check("relaunch_pass", 32'(pass_a), 1);
    check("relaunch_sig", 32'(sig_a), 32'h3);
    start_a = 1'b0;
    tick();

    // start toggled during RUN.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("tog_tm_k", 32'(tm_a), 1);
    tick();
    start_a = 1'b1;
    check("tog_tm_k1", 32'(tm_a), 1);
    tick();
    start_a = 1'b0;
    check("tog_tm_k2", 32'(tm_a), 0);
    check("tog_sig_k2", 32'(sig_a), 32'h3);
    tick();
    check("tog_done", 32'(done_a), 1);
    check("tog_pass", 32'(pass_a), 1);
    tick();

    // Table-driven streams through the scoreboard.
    for (int v = 0; v < 4; v++) begin
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      sb_q.push_back('{sig: vecs[v].exp_sig, pass: vecs[v].exp_pass});
      cut_d = vecs[v].w0;
      tick();
      cut_d = vecs[v].w1;
      tick();
      cut_d = vecs[v].w2;
      tick();
      tick();
      tick();
    end
    check("sb_drain", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
